// File: rtl/isp_loader_pkg.sv
// isp_loader_pkg: definitions shared by the ISP loader and the instruction-memory side.
// Holds the instruction bus width (`InstBus), the frame header byte, the loader state
// encodings and the clogb2 helper the BRAM uses to size its address bus.

`ifndef InstBus
`define InstBus 32
`endif

package isp_loader_pkg;

    // First byte of every loader frame
    localparam logic [7:0] ISP_HDR = 8'hA5;

    // Loader FSM states
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLen0 = 3'd1,
        StLen1 = 3'd2,
        StData = 3'd3,
        StCsum = 3'd4
    } isp_state_e;

    // Number of bits needed to represent value (0 for 0); matches the BRAM's sizing helper
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/isp_loader.sv
// isp_loader: write side of the dual-port instruction BRAM.
// Receives a framed byte stream (A5, LEN_L, LEN_H, N x 4 data bytes LSB first, CSUM),
// assembles little-endian words and writes them to consecutive addresses from 0.
// busy holds the core in reset while a frame is in progress; done/err are sticky until
// the next header byte.
// Build option: define ISP_CSUM_EN to expect and verify the trailing XOR checksum byte.
// Without it the frame ends after the last data word (or after LEN_H when N == 0).

`ifndef InstBus
`define InstBus 32
`endif

module isp_loader
    import isp_loader_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 65536,
    localparam int unsigned AW = clogb2(RAM_DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_vld,
    input  logic [7:0]            rx_data,
    output logic                  rx_rdy,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [`InstBus-1:0]   wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    isp_state_e              state_q;
    logic [7:0]              len_l_q;
    logic [15:0]             len_q;
    logic [16:0]             word_cnt_q;
    logic [1:0]              lane_q;
    // Holds the first three bytes of a word; the fourth goes straight into wr_data
    logic [`InstBus-9:0]     asm_q;
`ifdef ISP_CSUM_EN
    logic [7:0]              csum_q;
`endif

    logic                    rx_acc;
    logic [15:0]             len_full;
    logic                    len_oversize;
    logic                    word_last;

    // Byte handshake and frame-length decode
    always_comb begin
        rx_acc       = rx_vld & rx_rdy;
        len_full     = {rx_data, len_l_q};
        len_oversize = {16'd0, len_full} > RAM_DEPTH;
        word_last    = (word_cnt_q + 17'd1) == {1'b0, len_q};
    end

    // Loader FSM with registered handshake, write port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_l_q    <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            asm_q      <= '0;
`ifdef ISP_CSUM_EN
            csum_q     <= '0;
`endif
            rx_rdy     <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Write strobe and its back-pressure last exactly one cycle
            wr_en  <= 1'b0;
            rx_rdy <= 1'b1;
            if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
            end

            if (rx_acc) begin
                unique case (state_q)
                    StIdle: begin
                        // Anything other than the header is line noise between frames
                        if (rx_data == ISP_HDR) begin
                            done    <= 1'b0;
                            err     <= 1'b0;
                            wr_addr <= '0;
`ifdef ISP_CSUM_EN
                            csum_q  <= '0;
`endif
                            busy    <= 1'b1;
                            state_q <= StLen0;
                        end
                    end

                    StLen0: begin
                        len_l_q <= rx_data;
`ifdef ISP_CSUM_EN
                        csum_q  <= csum_q ^ rx_data;
`endif
                        state_q <= StLen1;
                    end

                    StLen1: begin
`ifdef ISP_CSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        if (len_full == 16'd0) begin
`ifdef ISP_CSUM_EN
                            state_q <= StCsum;
`else
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
`endif
                        end else if (len_oversize) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            len_q      <= len_full;
                            word_cnt_q <= '0;
                            lane_q     <= '0;
                            state_q    <= StData;
                        end
                    end

                    StData: begin
`ifdef ISP_CSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        lane_q <= lane_q + 2'd1;
                        asm_q  <= {rx_data, asm_q[`InstBus-9:8]};
                        if (lane_q == 2'd3) begin
                            // Word complete: write it and stall the receiver for one cycle
                            wr_data    <= {rx_data, asm_q};
                            wr_en      <= 1'b1;
                            rx_rdy     <= 1'b0;
                            word_cnt_q <= word_cnt_q + 17'd1;
                            if (word_last) begin
`ifdef ISP_CSUM_EN
                                state_q <= StCsum;
`else
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIdle;
`endif
                            end
                        end
                    end

`ifdef ISP_CSUM_EN
                    StCsum: begin
                        if (rx_data == csum_q) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
`endif

                    default: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isp_loader.sv
// tb_isp_loader: table-driven frame vectors plus a mid-frame reset sequence.
// Works with or without ISP_CSUM_EN; expectations follow the build option.

module tb_isp_loader;

    localparam int unsigned RAM_DEPTH = 4;
    localparam int unsigned AW = 2;
`ifdef ISP_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          rx_vld;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;

    isp_loader #(
        .RAM_DEPTH (RAM_DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_vld  (rx_vld),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and handshake observations, sampled mid-cycle
    int          wr_total = 0;
    int          rdy_low  = 0;
    int          rdy_bad  = 0;
    int          log_addr [256];
    logic [31:0] log_data [256];

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr[wr_total] <= int'(wr_addr);
            log_data[wr_total] <= wr_data;
            wr_total <= wr_total + 1;
        end
        if (!rx_rdy) rdy_low <= rdy_low + 1;
        if (wr_en == rx_rdy) rdy_bad <= rdy_bad + 1;
    end

    typedef struct {
        int               n;
        logic [3:0][31:0] w;
        bit               junk;
        bit               bad;
        bit               exp_done;
        bit               exp_err;
        int               exp_wr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input bit junk, input bit bad, input bit exp_done,
                                input bit exp_err, input int exp_wr);
        vec_t v;
        v.n = n;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.w[3] = w3;
        v.junk = junk;
        v.bad = bad;
        v.exp_done = exp_done;
        v.exp_err = exp_err;
        v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is accepted
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        rx_vld = 1'b1;
        rx_data = b;
        while (!rx_rdy && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_rdy) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: rx_rdy stuck low for byte %h", b);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int         base_wr;
        int         base_low;
        int         base_bad;
        logic [7:0] cs;
        logic [7:0] b;
        logic [15:0] n16;
        base_wr  = wr_total;
        base_low = rdy_low;
        base_bad = rdy_bad;
        n16 = v.n[15:0];
        if (v.junk) begin
            send_byte(8'h00);
            send_byte(8'hFF);
            check({tag, " junk_busy"}, {31'd0, busy}, 32'd0);
        end
        send_byte(8'hA5);
        check({tag, " hdr_flags"}, {29'd0, busy, done, err}, 32'd4);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        cs = n16[7:0] ^ n16[15:8];
        if (v.n <= int'(RAM_DEPTH)) begin
            for (int i = 0; i < v.n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = v.w[i][8*k +: 8];
                    cs = cs ^ b;
                    send_byte(b);
                end
            end
            if (CSUM_EN) send_byte(v.bad ? (cs ^ 8'h81) : cs);
        end
        rx_vld = 1'b0;
        // Status must be valid on the cycle right after the final byte
        check({tag, " end_flags"}, {29'd0, busy, done, err},
              {29'd0, 1'b0, v.exp_done, v.exp_err});
        @(negedge clk);
        @(negedge clk);
        check({tag, " nwr"}, wr_total - base_wr, v.exp_wr);
        for (int i = 0; i < v.exp_wr; i++) begin
            check({tag, " waddr"}, log_addr[base_wr + i], i);
            check({tag, " wdata"}, log_data[base_wr + i], v.w[i]);
        end
        check({tag, " rdy_low"}, rdy_low - base_low, v.exp_wr);
        check({tag, " rdy_vs_wen"}, rdy_bad - base_bad, 0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = mk(2, 32'h13, 32'h6F, 0, 0, 0, 0, 1, 0, 2);
        vecs[1] = mk(2, 32'h13, 32'h6F, 0, 0, 0, 1, !CSUM_EN, CSUM_EN, 2);
        vecs[2] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        vecs[3] = mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[4] = mk(4, 32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h00000001, 0, 0, 1, 0, 4);
        vecs[5] = mk(1, 32'h000000A5, 0, 0, 0, 1, 0, 1, 0, 1);
        vecs[6] = mk(3, 32'h00000001, 32'h80000002, 32'h00A50003, 0, 0, 0, 1, 0, 3);

        rst_n = 1'b0;
        rx_vld = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_outs", {25'd0, rx_rdy, wr_en, busy, done, err, wr_addr},
              {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        check("rst_wdata", wr_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_rdy", {31'd0, rx_rdy}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Reset after the second data byte of a 1-word frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rx_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {25'd0, rx_rdy, wr_en, busy, done, err, wr_addr},
              {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        check("midrst_wdata", wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(mk(1, 32'h0000006F, 0, 0, 0, 0, 0, 1, 0, 1), "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
